// File: rtl/pwm_duty_slew.sv
// pwm_duty_slew: slews a registered PWM duty toward a loaded target,
// one LSB every 2^rate_sel clocks, with a done pulse on arrival.
// Ports: clk, rst_n (async low), ena (global hold), tgt_in[7:0],
//   tgt_load (rising edge captures tgt_in), rate_sel[2:0],
//   duty_out[7:0], busy, done (1-cycle), ramp_dir (1 = up).
// Option: define PWM_SLEW_SYNC_EN to add a 2-flop synchroniser on
//   tgt_load (capture latency +2 clocks).
module pwm_duty_slew (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tgt_in,
    input  logic       tgt_load,
    input  logic [2:0] rate_sel,
    output logic [7:0] duty_out,
    output logic       busy,
    output logic       done,
    output logic       ramp_dir
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] duty_q, duty_d;
    logic [7:0] tgt_q, tgt_d;
    logic [6:0] presc_q, presc_d;
    logic       done_q, done_d;
    logic       load_q;
    logic       load_src;
    logic       capture;
    logic [7:0] term_lim;
    logic       presc_term;

`ifdef PWM_SLEW_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else if (ena) begin
            sync_q <= {sync_q[0], tgt_load};
        end
    end

    assign load_src = sync_q[1];
`else
    assign load_src = tgt_load;
`endif

    assign capture = ena & load_src & ~load_q;

    // Terminal count 2^rate_sel-1; ">=" lets a shortened interval
    // take effect on the very next edge.
    assign term_lim   = (8'd1 << rate_sel) - 8'd1;
    assign presc_term = ({1'b0, presc_q} >= term_lim);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (capture) begin
            tgt_d   = tgt_in;
            presc_d = 7'd0;
            if (tgt_in > duty_q) begin
                state_d = S_UP;
            end else if (tgt_in < duty_q) begin
                state_d = S_DOWN;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end else if (state_q != S_IDLE) begin
            if (presc_term) begin
                presc_d = 7'd0;
                unique case (1'b1)
                    (state_q == S_UP) && (duty_q != 8'hff):
                        duty_d = duty_q + 8'd1;
                    (state_q == S_DOWN) && (duty_q != 8'h00):
                        duty_d = duty_q - 8'd1;
                    default:
                        duty_d = duty_q;
                endcase
                if (duty_d == tgt_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + 7'd1;
            end
        end
        // Encoding 2'b11 is unreachable; fold it back to IDLE.
        if (state_d == 2'b11) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            duty_q  <= 8'd0;
            tgt_q   <= 8'd0;
            presc_q <= 7'd0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            load_q  <= load_src;
        end
    end

    assign duty_out = duty_q;
    assign done     = done_q;
    assign busy     = (state_q == S_UP) || (state_q == S_DOWN);
    assign ramp_dir = (state_q == S_UP);

endmodule

// File: tb/tb_pwm_duty_slew.sv
// tb_pwm_duty_slew: randomized and directed stimulus for pwm_duty_slew,
// checked every clock against a behavioural model of the slew rules.
module tb_pwm_duty_slew;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] tgt_in = 8'd0;
    logic       tgt_load = 1'b0;
    logic [2:0] rate_sel = 3'd0;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;
    logic       ramp_dir;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: duty walks toward target, one LSB per interval
    int m_duty = 0;
    int m_tgt  = 0;
    int m_wait = 0;
    int m_prev = 0;
    int m_done = 0;
    int m_s1   = 0;
    int m_s2   = 0;

    int busy_cnt = 0;
    int done_cnt = 0;

    pwm_duty_slew dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .tgt_in   (tgt_in),
        .tgt_load (tgt_load),
        .rate_sel (rate_sel),
        .duty_out (duty_out),
        .busy     (busy),
        .done     (done),
        .ramp_dir (ramp_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_duty = 0;
        m_tgt  = 0;
        m_wait = 0;
        m_prev = 0;
        m_done = 0;
        m_s1   = 0;
        m_s2   = 0;
    endtask

    task automatic model_step();
        int lsrc;
        if (!rst_n) begin
            model_reset();
        end else if (ena) begin
`ifdef PWM_SLEW_SYNC_EN
            lsrc = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(tgt_load);
`else
            lsrc = int'(tgt_load);
`endif
            m_done = 0;
            if (lsrc == 1 && m_prev == 0) begin
                m_tgt  = int'(tgt_in);
                m_wait = 0;
                m_done = (m_tgt == m_duty) ? 1 : 0;
            end else if (m_duty != m_tgt) begin
                m_wait++;
                if (m_wait >= (1 << rate_sel)) begin
                    m_wait = 0;
                    m_duty += (m_tgt > m_duty) ? 1 : -1;
                    m_done = (m_duty == m_tgt) ? 1 : 0;
                end
            end
            m_prev = lsrc;
        end
    endtask

    task automatic check_all();
        chk("duty", int'(duty_out), m_duty);
        chk("busy", int'(busy), (m_duty != m_tgt) ? 1 : 0);
        chk("dir", int'(ramp_dir), (m_tgt > m_duty) ? 1 : 0);
        chk("done", int'(done), m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int v);
        tgt_in   = 8'(v);
        tgt_load = 1'b1;
`ifdef PWM_SLEW_SYNC_EN
        run(3);
`else
        tick();
`endif
        tgt_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_duty", int'(duty_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dir", int'(ramp_dir), 0);
        run(2);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clr_cnt();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        int frz;
        do_reset();

        // ramp 0 -> 10 at full rate
        clr_cnt();
        rate_sel = 3'd0;
        load(10);
        run(14);
        chk("r028_duty", int'(duty_out), 10);
        chk("r028_busy", busy_cnt, 10);
        chk("r028_done", done_cnt, 1);

        // 10 -> 7, one step per 8 clocks
        clr_cnt();
        rate_sel = 3'd3;
        load(7);
        run(7);
        chk("r029_hold", int'(duty_out), 10);
        run(1);
        chk("r029_step", int'(duty_out), 9);
        run(20);
        chk("r029_duty", int'(duty_out), 7);
        chk("r029_done", done_cnt, 1);

        // retarget mid-ramp: 200 abandoned at 50, land on 20
        clr_cnt();
        rate_sel = 3'd0;
        load(200);
        while (m_duty != 50) tick();
        load(20);
        run(40);
        chk("r030_duty", int'(duty_out), 20);
        chk("r030_done", done_cnt, 1);

        // load equal to current duty
        clr_cnt();
        load(20);
        run(3);
        chk("r031_busy", busy_cnt, 0);
        chk("r031_done", done_cnt, 1);
        chk("r031_duty", int'(duty_out), 20);

        // freeze then reset mid-ramp
        load(100);
        run(5);
        frz = int'(duty_out);
        ena = 1'b0;
        run(20);
        chk("r032_frz", int'(duty_out), frz);
        chk("r032_fbusy", int'(busy), 1);
        ena = 1'b1;
        run(3);
        clr_cnt();
        do_reset();
        run(4);
        chk("r032_done", done_cnt, 0);
        chk("r032_duty", int'(duty_out), 0);

        // hard limits and slowest rate
        load(255);
        run(262);
        chk("r033_top", int'(duty_out), 255);
        rate_sel = 3'd7;
        load(0);
        run(127);
        chk("r033_slow", int'(duty_out), 255);
        run(1);
        chk("r033_s1", int'(duty_out), 254);
        run(128);
        chk("r033_s2", int'(duty_out), 253);
        rate_sel = 3'd0;
        run(260);
        chk("r033_bot", int'(duty_out), 0);
        chk("r033_busy", int'(busy), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            ena      = ($urandom_range(0, 9) != 0);
            tgt_load = ($urandom_range(0, 7) == 0);
            tgt_in   = 8'($urandom_range(0, 255));
            rate_sel = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_slew.md
PWM_DUTY_SLEW -- requirements
Module: pwm_duty_slew

Interface
REQ-001 Block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design enable; low freezes all registers.
REQ-005 tgt_in  input  8  requested target duty, unsigned, 0..255.
REQ-006 tgt_load  input  1  load request; a rising edge captures tgt_in.
REQ-007 rate_sel  input  3  step interval of 2^rate_sel clocks (1..128).
REQ-008 duty_out  output  8  registered slewed duty, fed to the downstream PWM duty input.
REQ-009 busy  output  1  high while state is RAMP_UP or RAMP_DOWN.
REQ-010 done  output  1  one-cycle pulse when duty_out reaches the target.
REQ-011 ramp_dir  output  1  1 = ramping up, 0 = down or idle.

Function
REQ-012 Block SHALL keep a registered copy of tgt_load; a capture occurs on an edge with ena=1, tgt_load=1 and copy=0.
REQ-013 On capture, block SHALL latch tgt_in into target_q and clear the 7-bit prescaler.
- Same edge: next state is RAMP_UP if tgt_in>duty_out, RAMP_DOWN if tgt_in<duty_out, else IDLE with done=1.
REQ-014 States SHALL be IDLE, RAMP_UP and RAMP_DOWN; no other state is reachable.
REQ-015 In a RAMP state with no capture, on each edge where prescaler >= 2^rate_sel-1:
- duty_out steps ±1 LSB;
- prescaler clears;
- otherwise prescaler increments.
REQ-016 A step that makes duty_out equal target_q SHALL also move the state to IDLE and set done=1 for that one cycle.
REQ-017 duty_out SHALL never overshoot target_q and never wrap (0 and 255 are hard limits).
REQ-018 A capture during a ramp SHALL retarget immediately.
- Direction is recomputed against the current duty_out and the prescaler restarts.
- done is not pulsed for the abandoned target.
REQ-019 A rate_sel change mid-ramp SHALL apply at the next comparison; a prescaler already past the new terminal steps on the next enabled edge.
REQ-020 Capture SHALL have priority over a coincident step; duty_out holds on that edge.
REQ-021 With ena=0, all registers SHALL hold, including the tgt_load copy; a level held across ena low creates no new edge.
REQ-022 busy and ramp_dir SHALL be decoded from registered state only; all outputs are glitch-free.
REQ-023 Latency: capture at edge k, rate_sel=0, |delta|=n SHALL give duty_out changes at edges k+1..k+n, with done at edge k+n.

Reset
REQ-024 rst_n low SHALL asynchronously set state IDLE, duty_out=0, target_q=0, prescaler=0, tgt_load copy=0, busy=0, done=0, ramp_dir=0.
REQ-025 Reset mid-ramp SHALL abandon the ramp with no done pulse; the first capture after release is evaluated against duty_out=0.

Configuration
REQ-026 Macro PWM_SLEW_SYNC_EN, when defined, SHALL insert a two-flop synchroniser on tgt_load ahead of the edge detector.
- Capture latency grows by 2 clocks.
- tgt_in is sampled on the capture edge.
REQ-027 Without PWM_SLEW_SYNC_EN, tgt_load SHALL feed the edge detector directly; the caller guarantees synchronous timing.

Verification
REQ-028 Reset, rate_sel=0, tgt_in=10, pulse tgt_load -> duty_out 1..10 on consecutive clocks, busy high 10 cycles, done single pulse with duty_out=10, ramp_dir=1 during ramp.
REQ-029 From duty_out=10, rate_sel=3, tgt_in=7 -> duty_out steps down every 8 clocks to 7, ramp_dir=0, done once.
REQ-030 Load tgt_in=200, then at duty_out=50 load tgt_in=20 -> no done for 200, reversal to RAMP_DOWN, single done at 20.
REQ-031 Load equal to current duty_out -> busy stays 0, done pulses once next edge, duty_out unchanged.
REQ-032 Mid-ramp: ena low 20 clocks, then rst_n low mid-ramp -> outputs frozen while disabled; reset gives duty_out=0, busy=0, no done.
REQ-033 tgt_in=255 then tgt_in=0, rate_sel=7 -> reaches 255 and 0 exactly, no wrap, 128 clocks per step.
